// File: rtl/booth2_mul_if.sv
// Operand/product bundle for the radix-4 Booth multiplier.
// master drives operands and observes the registered product; slave is the multiplier.
interface booth2_mul_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic [WIDTH-1:0]     m;
   logic [WIDTH-1:0]     q;
   logic [2*WIDTH-1:0]   p;
   logic                 out_valid;

   modport master (output in_valid, m, q, input p, out_valid);
   modport slave  (input in_valid, m, q, output p, out_valid);
endinterface

// File: rtl/booth2_mul.sv
// Signed WIDTH x WIDTH radix-4 Booth multiplier, full 2*WIDTH product.
// Latency 1 cycle, one operation per cycle, no backpressure; p holds when in_valid=0.
module booth2_mul #(
   parameter int WIDTH = 4
) (
   input logic         clk,
   input logic         rst,
   booth2_mul_if.slave bus
);
   localparam int QE = WIDTH + (WIDTH % 2);
   localparam int N  = QE / 2;
   localparam int PW = 2 * WIDTH;

   logic [PW-1:0] mext;
   logic [QE:0]   qe;
   logic [2:0]    trip;
   logic [PW-1:0] mag;
   logic          neg;
   logic [PW-1:0] acc;
   logic [PW-1:0] prod;

   always_comb begin
      mext = PW'(signed'(bus.m));
      // Sign-extended multiplier with the implicit q[-1]=0 appended at bit 0.
      qe   = {QE'(signed'(bus.q)), 1'b0};
      acc  = '0;
      trip = '0;
      mag  = '0;
      neg  = 1'b0;
      for (int i = 0; i < N; i++) begin
         trip = qe[2*i +: 3];
         case (trip)
            3'b001, 3'b010: begin mag = mext;      neg = 1'b0; end
            3'b011:         begin mag = mext << 1; neg = 1'b0; end
            3'b100:         begin mag = mext << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = mext;      neg = 1'b1; end
            default:        begin mag = '0;        neg = 1'b0; end
         endcase
         // Negative digits contribute ~mag plus a +1 injected at the digit's weight.
         acc = acc + ((neg ? ~mag : mag) << (2*i)) + (PW'(neg) << (2*i));
      end
      prod = acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.p         <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid)
            bus.p <= prod;
      end
   end
endmodule

// File: tb/tb_booth2_mul.sv
// Self-checking bench for booth2_mul at WIDTH 4, 5 and 8 against a plain signed-multiply model.
module tb_booth2_mul;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   booth2_mul_if #(.WIDTH(4)) if4 ();
   booth2_mul_if #(.WIDTH(5)) if5 ();
   booth2_mul_if #(.WIDTH(8)) if8 ();

   booth2_mul #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
   booth2_mul #(.WIDTH(5)) u5 (.clk(clk), .rst(rst), .bus(if5));
   booth2_mul #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

   function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
      longint x;
      x = longint'($signed(a)) * longint'($signed(b));
      return x[7:0];
   endfunction

   function automatic logic [9:0] ref5(input logic [4:0] a, input logic [4:0] b);
      longint x;
      x = longint'($signed(a)) * longint'($signed(b));
      return x[9:0];
   endfunction

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
      longint x;
      x = longint'($signed(a)) * longint'($signed(b));
      return x[15:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {m, q, expected p}
   localparam logic [15:0] DIR [12] = '{
      {4'h5, 4'h2, 8'h0A}, {4'h2, 4'h5, 8'h0A}, {4'h5, 4'h1, 8'h05},
      {4'h5, 4'h2, 8'h0A}, {4'h1, 4'h1, 8'h01}, {4'h2, 4'hF, 8'hFE},
      {4'hB, 4'hF, 8'h05}, {4'h5, 4'h0, 8'h00}, {4'h8, 4'h8, 8'h40},
      {4'h8, 4'h7, 8'hC8}, {4'h7, 4'h8, 8'hC8}, {4'h7, 4'h7, 8'h31}
   };

   task automatic test_reset();
      rst = 1'b1;
      if4.in_valid = 1'b1; if4.m = 4'h7; if4.q = 4'h7;
      if5.in_valid = 1'b0; if5.m = '0; if5.q = '0;
      if8.in_valid = 1'b0; if8.m = '0; if8.q = '0;
      step();
      step();
      vectors++;
      if (if4.p !== 8'h00 || if4.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_w4: got p=%h ov=%b expected p=00 ov=0", if4.p, if4.out_valid);
      end
      vectors++;
      if (if5.out_valid !== 1'b0 || if8.out_valid !== 1'b0 || if5.p !== '0 || if8.p !== '0) begin
         miscompares++;
         $display("FAIL reset_w58: got ov5=%b ov8=%b p5=%h p8=%h expected all zero",
                  if5.out_valid, if8.out_valid, if5.p, if8.p);
      end
      rst = 1'b0;
      if4.in_valid = 1'b0;
      step();
      step();
      vectors++;
      if (if4.p !== 8'h00 || if4.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: got p=%h ov=%b expected p=00 ov=0", if4.p, if4.out_valid);
      end
   endtask

   task automatic test_directed();
      logic [15:0] e;
      for (int k = 0; k < 12; k++) begin
         e = DIR[k];
         if4.in_valid = 1'b1;
         if4.m = e[15:12];
         if4.q = e[11:8];
         step();
         vectors++;
         if (if4.p !== e[7:0] || if4.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL directed[%0d] m=%h q=%h: got p=%h ov=%b expected p=%h ov=1",
                     k, e[15:12], e[11:8], if4.p, if4.out_valid, e[7:0]);
         end
      end
   endtask

   task automatic test_hold();
      logic [7:0] held;
      if4.in_valid = 1'b1; if4.m = 4'h3; if4.q = 4'hD;
      step();
      held = ref4(4'h3, 4'hD);
      vectors++;
      if (if4.p !== held || if4.out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_load: got p=%h ov=%b expected p=%h ov=1", if4.p, if4.out_valid, held);
      end
      if4.in_valid = 1'b0; if4.m = 'x; if4.q = 'x;
      step();
      vectors++;
      if (if4.p !== held || if4.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_idle: got p=%h ov=%b expected p=%h ov=0", if4.p, if4.out_valid, held);
      end
      if4.m = 4'h6; if4.q = 4'h6;
      step();
      vectors++;
      if (if4.p !== held || if4.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_idle2: got p=%h ov=%b expected p=%h ov=0", if4.p, if4.out_valid, held);
      end
   endtask

   task automatic test_reset_mid();
      if4.in_valid = 1'b1; if4.m = 4'h7; if4.q = 4'h5;
      step();
      vectors++;
      if (if4.p !== 8'h23 || if4.out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_pre: got p=%h ov=%b expected p=23 ov=1", if4.p, if4.out_valid);
      end
      rst = 1'b1; if4.m = 4'h6; if4.q = 4'h3;
      step();
      vectors++;
      if (if4.p !== 8'h00 || if4.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got p=%h ov=%b expected p=00 ov=0", if4.p, if4.out_valid);
      end
      rst = 1'b0; if4.in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         vectors++;
         if (if4.p !== 8'h00 || if4.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_discard[%0d]: got p=%h ov=%b expected p=00 ov=0",
                     k, if4.p, if4.out_valid);
         end
      end
   endtask

   task automatic test_exhaustive_w4();
      logic [3:0] a, b;
      logic [7:0] exp_p;
      for (int k = 0; k < 256; k++) begin
         a = 4'(k >> 4);
         b = 4'(k);
         if4.in_valid = 1'b1; if4.m = a; if4.q = b;
         step();
         exp_p = ref4(a, b);
         vectors++;
         if (if4.p !== exp_p || if4.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL exhaustive_w4 m=%h q=%h: got p=%h ov=%b expected p=%h ov=1",
                     a, b, if4.p, if4.out_valid, exp_p);
         end
      end
      if4.in_valid = 1'b0;
   endtask

   task automatic test_random_w5_w8();
      logic [9:0]  exp5;
      logic [15:0] exp8;
      logic        ev5, ev8;
      exp5 = if5.p; ev5 = 1'b0;
      exp8 = if8.p; ev8 = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if5.in_valid = ($urandom_range(0, 3) != 0);
         if5.m = 5'($urandom); if5.q = 5'($urandom);
         if8.in_valid = ($urandom_range(0, 3) != 0);
         if8.m = 8'($urandom); if8.q = 8'($urandom);
         if (k < 8) begin
            if5.m = (k[0]) ? 5'h10 : 5'h0F; if5.q = (k[1]) ? 5'h10 : 5'h0F;
            if8.m = (k[0]) ? 8'h80 : 8'h7F; if8.q = (k[1]) ? 8'h80 : 8'h7F;
            if5.in_valid = 1'b1; if8.in_valid = 1'b1;
         end
         ev5 = if5.in_valid;
         if (if5.in_valid) exp5 = ref5(if5.m, if5.q);
         ev8 = if8.in_valid;
         if (if8.in_valid) exp8 = ref8(if8.m, if8.q);
         step();
         vectors++;
         if (if5.p !== exp5 || if5.out_valid !== ev5) begin
            miscompares++;
            $display("FAIL random_w5[%0d]: got p=%h ov=%b expected p=%h ov=%b",
                     k, if5.p, if5.out_valid, exp5, ev5);
         end
         vectors++;
         if (if8.p !== exp8 || if8.out_valid !== ev8) begin
            miscompares++;
            $display("FAIL random_w8[%0d]: got p=%h ov=%b expected p=%h ov=%b",
                     k, if8.p, if8.out_valid, exp8, ev8);
         end
      end
      if5.in_valid = 1'b0;
      if8.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_exhaustive_w4();
      test_random_w5_w8();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
